// File: rtl/issue_queue_pkg.sv
`default_nettype none
// ============================================================================
// issue_queue_pkg : opcode, class and operand-source encodings for issue_queue
// Rev 1.0
// ============================================================================
package issue_queue_pkg;

  localparam int c_op_size  = 6;
  localparam int c_tag_size = 4;

  localparam logic [c_op_size-1:0] c_op_nop   = 6'd0;
  localparam logic [c_op_size-1:0] c_op_lui   = 6'd1;
  localparam logic [c_op_size-1:0] c_op_auipc = 6'd2;
  localparam logic [c_op_size-1:0] c_op_jal   = 6'd3;
  localparam logic [c_op_size-1:0] c_op_jalr  = 6'd4;
  localparam logic [c_op_size-1:0] c_op_beq   = 6'd5;
  localparam logic [c_op_size-1:0] c_op_bne   = 6'd6;
  localparam logic [c_op_size-1:0] c_op_blt   = 6'd7;
  localparam logic [c_op_size-1:0] c_op_bge   = 6'd8;
  localparam logic [c_op_size-1:0] c_op_bltu  = 6'd9;
  localparam logic [c_op_size-1:0] c_op_bgeu  = 6'd10;
  localparam logic [c_op_size-1:0] c_op_lb    = 6'd11;
  localparam logic [c_op_size-1:0] c_op_lh    = 6'd12;
  localparam logic [c_op_size-1:0] c_op_lw    = 6'd13;
  localparam logic [c_op_size-1:0] c_op_lbu   = 6'd14;
  localparam logic [c_op_size-1:0] c_op_lhu   = 6'd15;
  localparam logic [c_op_size-1:0] c_op_sb    = 6'd16;
  localparam logic [c_op_size-1:0] c_op_sh    = 6'd17;
  localparam logic [c_op_size-1:0] c_op_sw    = 6'd18;
  localparam logic [c_op_size-1:0] c_op_addi  = 6'd19;
  localparam logic [c_op_size-1:0] c_op_slti  = 6'd20;
  localparam logic [c_op_size-1:0] c_op_sltiu = 6'd21;
  localparam logic [c_op_size-1:0] c_op_xori  = 6'd22;
  localparam logic [c_op_size-1:0] c_op_ori   = 6'd23;
  localparam logic [c_op_size-1:0] c_op_andi  = 6'd24;
  localparam logic [c_op_size-1:0] c_op_slli  = 6'd25;
  localparam logic [c_op_size-1:0] c_op_srli  = 6'd26;
  localparam logic [c_op_size-1:0] c_op_srai  = 6'd27;
  localparam logic [c_op_size-1:0] c_op_add   = 6'd28;
  localparam logic [c_op_size-1:0] c_op_sub   = 6'd29;
  localparam logic [c_op_size-1:0] c_op_sll   = 6'd30;
  localparam logic [c_op_size-1:0] c_op_slt   = 6'd31;
  localparam logic [c_op_size-1:0] c_op_sltu  = 6'd32;
  localparam logic [c_op_size-1:0] c_op_xor   = 6'd33;
  localparam logic [c_op_size-1:0] c_op_srl   = 6'd34;
  localparam logic [c_op_size-1:0] c_op_sra   = 6'd35;
  localparam logic [c_op_size-1:0] c_op_or    = 6'd36;
  localparam logic [c_op_size-1:0] c_op_and   = 6'd37;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_LOAD, CLS_STORE, CLS_R, CLS_I,
    CLS_BR, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC
  } iclass_e;

  typedef enum logic [2:0] {
    SRC_REG, SRC_IMM, SRC_PC, SRC_ZERO, SRC_FOUR
  } src_sel_e;

  typedef enum logic [1:0] {
    UNIT_NONE, UNIT_RS, UNIT_LSB
  } unit_e;

  // Opcodes are grouped in contiguous ranges per class; anything else is NONE.
  function automatic iclass_e op_class(input logic [c_op_size-1:0] op);
    iclass_e c;
    c = CLS_NONE;
    if (op == c_op_lui)                          c = CLS_LUI;
    else if (op == c_op_auipc)                   c = CLS_AUIPC;
    else if (op == c_op_jal)                     c = CLS_JAL;
    else if (op == c_op_jalr)                    c = CLS_JALR;
    else if (op >= c_op_beq  && op <= c_op_bgeu) c = CLS_BR;
    else if (op >= c_op_lb   && op <= c_op_lhu)  c = CLS_LOAD;
    else if (op >= c_op_sb   && op <= c_op_sw)   c = CLS_STORE;
    else if (op >= c_op_addi && op <= c_op_srai) c = CLS_I;
    else if (op >= c_op_add  && op <= c_op_and)  c = CLS_R;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_queue_if.sv
`default_nettype none
// ============================================================================
// issue_queue_if : decode, regfile, CDB, ROB and dispatch signals of issue_queue
// Rev 1.0
// ============================================================================
interface issue_queue_if #(
  parameter int OP_W  = 6,
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
) ();
  logic             rdy_in;
  logic             clear;
  logic             dec_valid;
  logic             dec_ready;
  logic [OP_W-1:0]  dec_op;
  logic [4:0]       dec_rs1;
  logic [4:0]       dec_rs2;
  logic [4:0]       dec_rd;
  logic [XLEN-1:0]  dec_imm;
  logic [XLEN-1:0]  dec_pc;
  logic [4:0]       rf_rs1;
  logic [4:0]       rf_rs2;
  logic             rf_busy1;
  logic             rf_busy2;
  logic [TAG_W-1:0] rf_tag1;
  logic [TAG_W-1:0] rf_tag2;
  logic [XLEN-1:0]  rf_data1;
  logic [XLEN-1:0]  rf_data2;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;
  logic             rob_full;
  logic             rs_full;
  logic             lsb_full;
  logic [TAG_W-1:0] rob_tag;
  logic             rob_alloc;
  logic [OP_W-1:0]  rob_op;
  logic [4:0]       rob_rd;
  logic [XLEN-1:0]  rob_pc;
  logic [XLEN-1:0]  rob_imm;
  logic             ren_we;
  logic [4:0]       ren_rd;
  logic [TAG_W-1:0] ren_tag;
  logic             rs_valid;
  logic             lsb_valid;
  logic [OP_W-1:0]  is_op;
  logic             is_q1_busy;
  logic             is_q2_busy;
  logic [TAG_W-1:0] is_q1;
  logic [TAG_W-1:0] is_q2;
  logic [XLEN-1:0]  is_v1;
  logic [XLEN-1:0]  is_v2;
  logic [XLEN-1:0]  is_imm;
  logic [TAG_W-1:0] is_dest;

  modport master (
    output rdy_in, clear, dec_valid, dec_op, dec_rs1, dec_rs2, dec_rd, dec_imm, dec_pc,
    output rf_busy1, rf_busy2, rf_tag1, rf_tag2, rf_data1, rf_data2,
    output cdb_valid, cdb_tag, cdb_data, rob_full, rs_full, lsb_full, rob_tag,
    input  dec_ready, rf_rs1, rf_rs2, rob_alloc, rob_op, rob_rd, rob_pc, rob_imm,
    input  ren_we, ren_rd, ren_tag, rs_valid, lsb_valid, is_op,
    input  is_q1_busy, is_q2_busy, is_q1, is_q2, is_v1, is_v2, is_imm, is_dest
  );

  modport slave (
    input  rdy_in, clear, dec_valid, dec_op, dec_rs1, dec_rs2, dec_rd, dec_imm, dec_pc,
    input  rf_busy1, rf_busy2, rf_tag1, rf_tag2, rf_data1, rf_data2,
    input  cdb_valid, cdb_tag, cdb_data, rob_full, rs_full, lsb_full, rob_tag,
    output dec_ready, rf_rs1, rf_rs2, rob_alloc, rob_op, rob_rd, rob_pc, rob_imm,
    output ren_we, ren_rd, ren_tag, rs_valid, lsb_valid, is_op,
    output is_q1_busy, is_q2_busy, is_q1, is_q2, is_v1, is_v2, is_imm, is_dest
  );
endinterface
`default_nettype wire

// File: rtl/issue_queue_classify.sv
`default_nettype none
// ============================================================================
// issue_queue_classify : maps an opcode to target unit, operand sources, rd write
// Rev 1.0
// ============================================================================
module issue_queue_classify
  import issue_queue_pkg::*;
(
  input  logic [c_op_size-1:0] i_op,
  output unit_e                o_unit,
  output src_sel_e             o_sel1,
  output src_sel_e             o_sel2,
  output logic                 o_writes_rd,
  output logic                 o_imm_out
);

  iclass_e w_cls;

  always_comb begin
    w_cls       = op_class(i_op);
    o_unit      = UNIT_RS;
    o_sel1      = SRC_REG;
    o_sel2      = SRC_REG;
    o_writes_rd = 1'b1;
    o_imm_out   = 1'b0;
    case (w_cls)
      CLS_LOAD:  begin o_unit = UNIT_LSB; o_sel2 = SRC_IMM; end
      CLS_STORE: begin o_unit = UNIT_LSB; o_writes_rd = 1'b0; o_imm_out = 1'b1; end
      CLS_R:     begin end
      CLS_I:     o_sel2 = SRC_IMM;
      CLS_BR:    begin o_writes_rd = 1'b0; o_imm_out = 1'b1; end
      CLS_JAL:   begin o_sel1 = SRC_PC; o_sel2 = SRC_FOUR; end
      CLS_JALR:  begin o_sel2 = SRC_IMM; o_imm_out = 1'b1; end
      CLS_LUI:   begin o_sel1 = SRC_ZERO; o_sel2 = SRC_IMM; end
      CLS_AUIPC: begin o_sel1 = SRC_PC; o_sel2 = SRC_IMM; end
      default: begin
        o_unit      = UNIT_NONE;
        o_sel1      = SRC_ZERO;
        o_sel2      = SRC_ZERO;
        o_writes_rd = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
// issue_queue : in-order DEPTH-entry issue buffer between ID and ROB/RS/LSB
// Rev 1.0
// ============================================================================
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OP_W  = c_op_size,
  parameter int TAG_W = c_tag_size,
  parameter int XLEN  = 32
) (
  input  logic         clk_in,
  input  logic         rst_in,
  issue_queue_if.slave bus
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } entry_t;

  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } opnd_t;

  // A CDB hit on the producer tag bypasses the regfile in the same cycle.
  function automatic opnd_t resolve_reg(
    input logic [4:0]       rs,
    input logic             busy,
    input logic [TAG_W-1:0] tag,
    input logic [XLEN-1:0]  data,
    input logic             cdb_v,
    input logic [TAG_W-1:0] cdb_t,
    input logic [XLEN-1:0]  cdb_d
  );
    opnd_t r;
    r = '0;
    if (rs == 5'd0)                   r = '0;
    else if (!busy)                   r.val = data;
    else if (cdb_v && (cdb_t == tag)) r.val = cdb_d;
    else begin
      r.busy = 1'b1;
      r.tag  = tag;
    end
    return r;
  endfunction

  function automatic opnd_t pick(
    input src_sel_e        sel,
    input opnd_t           reg_op,
    input logic [XLEN-1:0] imm,
    input logic [XLEN-1:0] pc
  );
    opnd_t r;
    r = '0;
    case (sel)
      SRC_REG:  r = reg_op;
      SRC_IMM:  r.val = imm;
      SRC_PC:   r.val = pc;
      SRC_FOUR: r.val = XLEN'(4);
      default:  r = '0;
    endcase
    return r;
  endfunction

  logic [c_ptr_w-1:0] head_q, head_d, tail_q, tail_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];

  entry_t   w_head, w_new;
  unit_e    w_unit;
  src_sel_e w_sel1, w_sel2;
  logic     w_writes_rd, w_imm_out;
  logic     w_nonempty, w_dec_ready, w_push, w_fire, w_unit_full;
  opnd_t    w_reg1, w_reg2, w_op1, w_op2;

  issue_queue_classify u_classify (
    .i_op        (c_op_size'(w_head.op)),
    .o_unit      (w_unit),
    .o_sel1      (w_sel1),
    .o_sel2      (w_sel2),
    .o_writes_rd (w_writes_rd),
    .o_imm_out   (w_imm_out)
  );

  always_comb begin
    w_head      = mem_q[head_q];
    w_new       = '{op: bus.dec_op, rs1: bus.dec_rs1, rs2: bus.dec_rs2, rd: bus.dec_rd,
                    imm: bus.dec_imm, pc: bus.dec_pc};
    w_nonempty  = (count_q != '0);
    w_dec_ready = bus.rdy_in && !bus.clear && (count_q < c_cnt_w'(DEPTH));
    w_push      = bus.dec_valid && w_dec_ready;
    w_unit_full = ((w_unit == UNIT_RS) && bus.rs_full) || ((w_unit == UNIT_LSB) && bus.lsb_full);
    w_fire      = bus.rdy_in && !bus.clear && w_nonempty && !bus.rob_full && !w_unit_full;
    w_reg1      = resolve_reg(w_head.rs1, bus.rf_busy1, bus.rf_tag1, bus.rf_data1,
                              bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    w_reg2      = resolve_reg(w_head.rs2, bus.rf_busy2, bus.rf_tag2, bus.rf_data2,
                              bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    w_op1       = w_nonempty ? pick(w_sel1, w_reg1, w_head.imm, w_head.pc) : '0;
    w_op2       = w_nonempty ? pick(w_sel2, w_reg2, w_head.imm, w_head.pc) : '0;
  end

  // Freeze dominates everything; clear dominates push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (bus.rdy_in && bus.clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_push) begin
        mem_d[tail_q] = w_new;
        tail_d        = tail_q + c_ptr_w'(1);
      end
      if (w_fire) head_d = head_q + c_ptr_w'(1);
      case ({w_push, w_fire})
        2'b10:   count_d = count_q + c_cnt_w'(1);
        2'b01:   count_d = count_q - c_cnt_w'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign bus.dec_ready  = w_dec_ready;
  assign bus.rf_rs1     = w_nonempty ? w_head.rs1 : 5'd0;
  assign bus.rf_rs2     = w_nonempty ? w_head.rs2 : 5'd0;
  assign bus.rob_alloc  = w_fire && (w_unit != UNIT_NONE);
  assign bus.rs_valid   = w_fire && (w_unit == UNIT_RS);
  assign bus.lsb_valid  = w_fire && (w_unit == UNIT_LSB);
  assign bus.ren_we     = w_fire && w_writes_rd && (w_head.rd != 5'd0);
  assign bus.rob_op     = w_nonempty ? w_head.op  : '0;
  assign bus.rob_rd     = w_nonempty ? w_head.rd  : 5'd0;
  assign bus.rob_pc     = w_nonempty ? w_head.pc  : '0;
  assign bus.rob_imm    = w_nonempty ? w_head.imm : '0;
  assign bus.ren_rd     = w_nonempty ? w_head.rd  : 5'd0;
  assign bus.ren_tag    = w_nonempty ? bus.rob_tag : '0;
  assign bus.is_dest    = w_nonempty ? bus.rob_tag : '0;
  assign bus.is_op      = w_nonempty ? w_head.op  : '0;
  assign bus.is_imm     = (w_nonempty && w_imm_out) ? w_head.imm : '0;
  assign bus.is_q1_busy = w_op1.busy;
  assign bus.is_q1      = w_op1.tag;
  assign bus.is_v1      = w_op1.val;
  assign bus.is_q2_busy = w_op2.busy;
  assign bus.is_q2      = w_op2.tag;
  assign bus.is_v2      = w_op2.val;

endmodule
`default_nettype wire

// File: tb/tb_issue_queue.sv
`default_nettype none
// ============================================================================
// tb_issue_queue : randomized issue_queue stimulus against a queue-based model
// Rev 1.0
// ============================================================================
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int c_depth = 4;
  localparam int c_op_w  = 6;
  localparam int c_tag_w = 4;
  localparam int c_xlen  = 32;

  localparam int c_k_none = 0, c_k_load = 1, c_k_store = 2, c_k_r = 3, c_k_i = 4;
  localparam int c_k_br = 5, c_k_jal = 6, c_k_jalr = 7, c_k_lui = 8, c_k_auipc = 9;
  localparam int c_s_reg = 0, c_s_imm = 1, c_s_pc = 2, c_s_zero = 3, c_s_four = 4;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
  } ins_t;

  logic clk_in;
  logic rst_in;
  int   n_checks;
  int   n_fail;
  ins_t mq [$];

  issue_queue_if #(.OP_W(c_op_w), .TAG_W(c_tag_w), .XLEN(c_xlen)) bus ();

  issue_queue #(.DEPTH(c_depth), .OP_W(c_op_w), .TAG_W(c_tag_w), .XLEN(c_xlen)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int kind_of(input int o);
    if (o == int'(c_op_lui))                              return c_k_lui;
    if (o == int'(c_op_auipc))                            return c_k_auipc;
    if (o == int'(c_op_jal))                              return c_k_jal;
    if (o == int'(c_op_jalr))                             return c_k_jalr;
    if (o >= int'(c_op_beq)  && o <= int'(c_op_bgeu))     return c_k_br;
    if (o >= int'(c_op_lb)   && o <= int'(c_op_lhu))      return c_k_load;
    if (o >= int'(c_op_sb)   && o <= int'(c_op_sw))       return c_k_store;
    if (o >= int'(c_op_addi) && o <= int'(c_op_srai))     return c_k_i;
    if (o >= int'(c_op_add)  && o <= int'(c_op_and))      return c_k_r;
    return c_k_none;
  endfunction

  task automatic exp_operand(input int src, input ins_t h, input logic [4:0] rs,
                             input logic busy, input logic [3:0] tag, input logic [31:0] data,
                             output logic eb, output logic [3:0] et, output logic [31:0] ev);
    eb = 1'b0; et = 4'h0; ev = 32'h0;
    case (src)
      c_s_imm:  ev = h.imm;
      c_s_pc:   ev = h.pc;
      c_s_four: ev = 32'd4;
      c_s_reg: begin
        if (rs == 5'd0)                                    ev = 32'h0;
        else if (!busy)                                    ev = data;
        else if (bus.cdb_valid && (bus.cdb_tag == tag))    ev = bus.cdb_data;
        else begin eb = 1'b1; et = tag; end
      end
      default: ;
    endcase
  endtask

  task automatic drive_idle();
    bus.rdy_in = 1'b1;   bus.clear = 1'b0;   bus.dec_valid = 1'b0;
    bus.dec_op = '0;     bus.dec_rs1 = '0;   bus.dec_rs2 = '0;     bus.dec_rd = '0;
    bus.dec_imm = '0;    bus.dec_pc = '0;
    bus.rf_busy1 = 1'b0; bus.rf_busy2 = 1'b0; bus.rf_tag1 = '0;    bus.rf_tag2 = '0;
    bus.rf_data1 = '0;   bus.rf_data2 = '0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0;  bus.cdb_data = '0;
    bus.rob_full = 1'b0; bus.rs_full = 1'b0; bus.lsb_full = 1'b0;  bus.rob_tag = '0;
  endtask

  task automatic drive_rand(input int p_valid, input int p_full, input int p_clear);
    int r;
    bus.rdy_in    = ($urandom_range(0, 99) < 90);
    bus.clear     = bus.rdy_in && ($urandom_range(0, 99) < p_clear);
    bus.dec_valid = ($urandom_range(0, 99) < p_valid);
    r = $urandom_range(0, 99);
    if (r < 4)      bus.dec_op = 6'd0;
    else if (r < 9) bus.dec_op = 6'($urandom_range(38, 63));
    else            bus.dec_op = 6'($urandom_range(1, 37));
    bus.dec_rs1   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    bus.dec_rs2   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    bus.dec_rd    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    bus.dec_imm   = $urandom;
    bus.dec_pc    = $urandom;
    bus.rf_busy1  = $urandom_range(0, 1) != 0;
    bus.rf_busy2  = $urandom_range(0, 1) != 0;
    bus.rf_tag1   = 4'($urandom_range(0, 3));
    bus.rf_tag2   = 4'($urandom_range(0, 3));
    bus.rf_data1  = $urandom;
    bus.rf_data2  = $urandom;
    bus.cdb_valid = $urandom_range(0, 1) != 0;
    bus.cdb_tag   = 4'($urandom_range(0, 3));
    bus.cdb_data  = $urandom;
    bus.rob_full  = ($urandom_range(0, 99) < p_full);
    bus.rs_full   = ($urandom_range(0, 99) < p_full);
    bus.lsb_full  = ($urandom_range(0, 99) < p_full);
    bus.rob_tag   = 4'($urandom);
  endtask

  // Inputs are driven at the falling edge; compare, advance the model, wait one cycle.
  task automatic step();
    ins_t h, n;
    int k, s1, s2;
    logic emp, is_lsb, is_rs, wr, imm_pass, ufull, e_ready, e_fire;
    logic eb1, eb2;
    logic [3:0] et1, et2, etag;
    logic [31:0] ev1, ev2;
    #1;
    emp      = (mq.size() == 0);
    h        = emp ? ins_t'('0) : mq[0];
    k        = emp ? c_k_none : kind_of(int'(h.op));
    is_lsb   = (k == c_k_load) || (k == c_k_store);
    is_rs    = (k != c_k_none) && !is_lsb;
    wr       = k inside {c_k_load, c_k_r, c_k_i, c_k_jal, c_k_jalr, c_k_lui, c_k_auipc};
    imm_pass = k inside {c_k_store, c_k_br, c_k_jalr};
    case (k)
      c_k_jal, c_k_auipc: s1 = c_s_pc;
      c_k_lui, c_k_none:  s1 = c_s_zero;
      default:            s1 = c_s_reg;
    endcase
    case (k)
      c_k_store, c_k_r, c_k_br: s2 = c_s_reg;
      c_k_jal:                  s2 = c_s_four;
      c_k_none:                 s2 = c_s_zero;
      default:                  s2 = c_s_imm;
    endcase
    exp_operand(s1, h, h.rs1, bus.rf_busy1, bus.rf_tag1, bus.rf_data1, eb1, et1, ev1);
    exp_operand(s2, h, h.rs2, bus.rf_busy2, bus.rf_tag2, bus.rf_data2, eb2, et2, ev2);
    ufull   = is_lsb ? bus.lsb_full : (is_rs ? bus.rs_full : 1'b0);
    e_ready = bus.rdy_in && !bus.clear && (mq.size() < c_depth);
    e_fire  = bus.rdy_in && !bus.clear && !emp && !bus.rob_full && !ufull;
    etag    = emp ? 4'h0 : bus.rob_tag;

    check_val("dec_ready", 64'(bus.dec_ready), 64'(e_ready));
    check_val("strobes", 64'({bus.rob_alloc, bus.rs_valid, bus.lsb_valid, bus.ren_we}),
              64'({e_fire && (k != c_k_none), e_fire && is_rs, e_fire && is_lsb,
                   e_fire && wr && (h.rd != 5'd0)}));
    check_val("rf_rs", 64'({bus.rf_rs1, bus.rf_rs2}), 64'({h.rs1, h.rs2}));
    check_val("rob_op_rd", 64'({bus.rob_op, bus.rob_rd}), 64'({h.op, h.rd}));
    check_val("rob_pc", 64'(bus.rob_pc), 64'(h.pc));
    check_val("rob_imm", 64'(bus.rob_imm), 64'(h.imm));
    check_val("ren_rd_tag", 64'({bus.ren_rd, bus.ren_tag}), 64'({h.rd, etag}));
    check_val("is_op_dest", 64'({bus.is_op, bus.is_dest}), 64'({h.op, etag}));
    check_val("is_q", 64'({bus.is_q1_busy, bus.is_q1, bus.is_q2_busy, bus.is_q2}),
              64'({eb1, et1, eb2, et2}));
    check_val("is_v1", 64'(bus.is_v1), 64'(ev1));
    check_val("is_v2", 64'(bus.is_v2), 64'(ev2));
    check_val("is_imm", 64'(bus.is_imm), 64'(imm_pass ? h.imm : 32'h0));

    n = '{op: bus.dec_op, rs1: bus.dec_rs1, rs2: bus.dec_rs2, rd: bus.dec_rd,
          imm: bus.dec_imm, pc: bus.dec_pc};
    if (rst_in) mq.delete();
    else if (bus.rdy_in) begin
      if (bus.clear) mq.delete();
      else begin
        if (e_fire) void'(mq.pop_front());
        if (bus.dec_valid && e_ready) mq.push_back(n);
      end
    end
    @(negedge clk_in);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_in   = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    repeat (2) begin
      drive_rand(80, 20, 0);
      step();
    end
    rst_in = 1'b0;

    drive_idle();
    bus.dec_valid = 1'b1; bus.dec_op = c_op_addi; bus.dec_rs1 = 5'd0; bus.dec_rd = 5'd1;
    bus.dec_imm = 32'd5;  bus.dec_pc = 32'h10;
    step();
    drive_idle();
    bus.rob_tag = 4'h3;
    step();

    for (int i = 0; i < 6; i++) begin
      drive_rand(100, 0, 0);
      bus.rdy_in = 1'b1; bus.clear = 1'b0; bus.dec_valid = 1'b1; bus.rob_full = 1'b1;
      step();
    end
    for (int i = 0; i < 6; i++) begin
      drive_rand(0, 0, 0);
      bus.rdy_in = 1'b1; bus.clear = 1'b0;
      step();
    end

    for (int i = 0; i < 3000; i++) begin
      if (i < 1500) drive_rand(60, 25, 3);
      else          drive_rand(85, 45, 1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
